// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// operand_fetch_stage
//
// Sits directly behind the register file. Drives the file's read selects
// from the decoded instruction, resolves operands (zero register, same-cycle
// write-back bypass, immediate), and captures them into a registered output
// latch for the execute stage. A busy scoreboard tracks registers with an
// outstanding write and stalls read-after-write and write-after-write hazards.
//
// Ports
//   in_clk, in_rst            clock, asynchronous active-high reset
//   in_valid / out_ready      upstream handshake (decoded instruction)
//   in_ra, in_rb, in_rd       source / destination register indices
//   in_wr_en                  instruction writes in_rd
//   in_imm, in_use_imm        immediate replaces operand B when selected
//   out_SA, out_SB            register-file read selects (combinational)
//   in_PA, in_PB              register-file read data
//   in_wb_SC/PC/RFL           write-back index / data / enable (file port C)
//   in_flush                  kill the instruction held in the output latch
//   out_valid / in_ready      downstream handshake
//   out_A, out_B, out_rd, out_wr_en   latched instruction for execute
// ---------------------------------------------------------------------------
module operand_fetch_stage #(
   parameter int DATA_W = 32,
   parameter int REG_N  = 32,
   localparam int IDX_W = $clog2(REG_N)
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic              in_valid,
   output logic              out_ready,
   input  logic [IDX_W-1:0]  in_ra,
   input  logic [IDX_W-1:0]  in_rb,
   input  logic [IDX_W-1:0]  in_rd,
   input  logic              in_wr_en,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   output logic [IDX_W-1:0]  out_SA,
   output logic [IDX_W-1:0]  out_SB,
   input  logic [DATA_W-1:0] in_PA,
   input  logic [DATA_W-1:0] in_PB,
   input  logic [IDX_W-1:0]  in_wb_SC,
   input  logic [DATA_W-1:0] in_wb_PC,
   input  logic              in_wb_RFL,
   input  logic              in_flush,
   output logic              out_valid,
   input  logic              in_ready,
   output logic [DATA_W-1:0] out_A,
   output logic [DATA_W-1:0] out_B,
   output logic [IDX_W-1:0]  out_rd,
   output logic              out_wr_en
);

   // Resolve one register operand: r0 reads as zero, and a write-back
   // landing on the same register this cycle is forwarded because the
   // file only commits it at the coming edge.
   function automatic logic [DATA_W-1:0] resolve_operand(
      input logic [IDX_W-1:0]  idx,
      input logic [DATA_W-1:0] file_data,
      input logic              wb_en,
      input logic [IDX_W-1:0]  wb_idx,
      input logic [DATA_W-1:0] wb_data
   );
      if (idx == '0)
         return '0;
      else if (wb_en && (wb_idx == idx))
         return wb_data;
      else
         return file_data;
   endfunction

   logic [REG_N-1:0]  busy;
   logic [REG_N-1:0]  busy_eff;
   logic [REG_N-1:0]  busy_next;
   logic [DATA_W-1:0] op_a_p0;
   logic [DATA_W-1:0] op_b_p0;
   logic              hazard;
   logic              capture;

   assign out_SA = in_ra;
   assign out_SB = in_rb;

   assign op_a_p0 = resolve_operand(in_ra, in_PA, in_wb_RFL, in_wb_SC, in_wb_PC);
   assign op_b_p0 = in_use_imm ? in_imm
                  : resolve_operand(in_rb, in_PB, in_wb_RFL, in_wb_SC, in_wb_PC);

   // A write-back retiring this cycle releases its register immediately,
   // so a dependent instruction captures with bypassed data and no bubble.
   always_comb begin
      busy_eff = busy;
      if (in_wb_RFL)
         busy_eff[in_wb_SC] = 1'b0;
   end

   always_comb begin
      hazard = 1'b0;
      if (busy_eff[in_ra] && (in_ra != '0))
         hazard = 1'b1;
      if (!in_use_imm && busy_eff[in_rb] && (in_rb != '0))
         hazard = 1'b1;
      if (in_wr_en && busy_eff[in_rd] && (in_rd != '0))
         hazard = 1'b1;
   end

   assign out_ready = !hazard && !in_flush && (!out_valid || in_ready);
   assign capture   = in_valid && out_ready;

   // Clears are applied first so that a capture setting the same bit wins.
   always_comb begin
      busy_next = busy;
      if (in_wb_RFL)
         busy_next[in_wb_SC] = 1'b0;
      if (in_flush && out_valid && out_wr_en && (out_rd != '0))
         busy_next[out_rd] = 1'b0;
      if (capture && in_wr_en && (in_rd != '0))
         busy_next[in_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // ---- stage boundary: operand latch presented to execute ----
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         out_valid <= 1'b0;
         busy      <= '0;
      end else begin
         busy <= busy_next;
         if (in_flush)
            out_valid <= 1'b0;
         else if (capture)
            out_valid <= 1'b1;
         else if (in_ready)
            out_valid <= 1'b0;
      end
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         out_A     <= '0;
         out_B     <= '0;
         out_rd    <= '0;
         out_wr_en <= 1'b0;
      end else if (capture) begin
         out_A     <= op_a_p0;
         out_B     <= op_b_p0;
         out_rd    <= in_rd;
         out_wr_en <= in_wr_en;
      end
   end

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

   logic        in_clk;
   logic        in_rst;
   logic        in_valid;
   logic        out_ready;
   logic [4:0]  in_ra, in_rb, in_rd;
   logic        in_wr_en;
   logic [31:0] in_imm;
   logic        in_use_imm;
   logic [4:0]  out_SA, out_SB;
   logic [31:0] in_PA, in_PB;
   logic [4:0]  in_wb_SC;
   logic [31:0] in_wb_PC;
   logic        in_wb_RFL;
   logic        in_flush;
   logic        out_valid;
   logic        in_ready;
   logic [31:0] out_A, out_B;
   logic [4:0]  out_rd;
   logic        out_wr_en;

   logic [31:0] rf [32];
   int          n_checks;
   int          n_fail;

   operand_fetch_stage #(.DATA_W(32), .REG_N(32)) dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid), .out_ready(out_ready),
      .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_wr_en(in_wr_en),
      .in_imm(in_imm), .in_use_imm(in_use_imm), .out_SA(out_SA), .out_SB(out_SB),
      .in_PA(in_PA), .in_PB(in_PB), .in_wb_SC(in_wb_SC), .in_wb_PC(in_wb_PC),
      .in_wb_RFL(in_wb_RFL), .in_flush(in_flush), .out_valid(out_valid),
      .in_ready(in_ready), .out_A(out_A), .out_B(out_B), .out_rd(out_rd),
      .out_wr_en(out_wr_en)
   );

   // Register-file read model: the DUT's selects address the file.
   assign in_PA = rf[out_SA];
   assign in_PB = rf[out_SB];

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic instr(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                        input logic wr, input logic use_imm, input logic [31:0] imm);
      in_valid   = 1'b1;
      in_ra      = ra;
      in_rb      = rb;
      in_rd      = rd;
      in_wr_en   = wr;
      in_use_imm = use_imm;
      in_imm     = imm;
   endtask

   task automatic wb(input logic en, input logic [4:0] sc, input logic [31:0] pc);
      in_wb_RFL = en;
      in_wb_SC  = sc;
      in_wb_PC  = pc;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[0] = 32'h0000_DEAD;
      rf[1] = 32'h0000_0011;
      rf[2] = 32'h0000_0022;
      rf[3] = 32'h0000_0004;
      rf[4] = 32'hFFFF_FFFF;
      in_rst = 1'b1;
      in_valid = 1'b0; in_ra = '0; in_rb = '0; in_rd = '0; in_wr_en = 1'b0;
      in_imm = '0; in_use_imm = 1'b0; in_flush = 1'b0; in_ready = 1'b1;
      wb(1'b0, 5'd0, 32'h0);
      #1;
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_A", out_A, 32'h0);
      check("rst_rd", {27'b0, out_rd}, 32'h0);
      check("rst_busy", dut.busy, 32'h0);
      check("rst_ready", {31'b0, out_ready}, 32'h1);
      step();
      in_rst = 1'b0;

      // Basic read
      instr(5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 32'h0);
      #1;
      check("sel_SA", {27'b0, out_SA}, 32'd3);
      check("sel_SB", {27'b0, out_SB}, 32'd4);
      check("basic_ready", {31'b0, out_ready}, 32'h1);
      step();
      check("basic_A", out_A, 32'h0000_0004);
      check("basic_B", out_B, 32'hFFFF_FFFF);
      check("basic_rd", {27'b0, out_rd}, 32'd7);
      check("basic_valid", {31'b0, out_valid}, 32'h1);
      check("basic_busy", dut.busy, 32'h0000_0080);

      // RAW stall then release by same-cycle write-back
      instr(5'd7, 5'd0, 5'd8, 1'b0, 1'b0, 32'h0);
      #1;
      check("raw_stall", {31'b0, out_ready}, 32'h0);
      step();
      check("raw_drain", {31'b0, out_valid}, 32'h0);
      check("raw_hold_A", out_A, 32'h0000_0004);
      check("raw_still_stall", {31'b0, out_ready}, 32'h0);
      wb(1'b1, 5'd7, 32'h0000_1234);
      #1;
      check("raw_release", {31'b0, out_ready}, 32'h1);
      step();
      check("raw_bypass_A", out_A, 32'h0000_1234);
      check("raw_B_zero", out_B, 32'h0);
      check("raw_busy", dut.busy, 32'h0);

      // Zero register and write-back to r0
      instr(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0);
      wb(1'b1, 5'd0, 32'h0000_5555);
      #1;
      check("zero_ready", {31'b0, out_ready}, 32'h1);
      step();
      check("zero_A", out_A, 32'h0);
      check("zero_B", out_B, 32'h0);
      check("zero_busy", dut.busy, 32'h0);

      // Bypass on operand B
      instr(5'd0, 5'd4, 5'd10, 1'b1, 1'b0, 32'h0);
      wb(1'b1, 5'd4, 32'h0000_0077);
      step();
      check("bypB_B", out_B, 32'h0000_0077);
      check("bypB_busy", dut.busy, 32'h0000_0400);
      wb(1'b0, 5'd0, 32'h0);

      // Immediate: busy rb must be ignored
      instr(5'd3, 5'd10, 5'd9, 1'b1, 1'b1, 32'h0000_ABCD);
      #1;
      check("imm_ready", {31'b0, out_ready}, 32'h1);
      step();
      check("imm_A", out_A, 32'h0000_0004);
      check("imm_B", out_B, 32'h0000_ABCD);
      check("imm_busy", dut.busy, 32'h0000_0600);

      // Flush with out_rd=9, simultaneous in_valid refused
      instr(5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 32'h0);
      in_flush = 1'b1;
      #1;
      check("flush_ready", {31'b0, out_ready}, 32'h0);
      step();
      in_flush = 1'b0;
      check("flush_valid", {31'b0, out_valid}, 32'h0);
      check("flush_busy", dut.busy, 32'h0000_0400);

      // Back-pressure
      instr(5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 32'h0);
      step();
      check("bp_load_A", out_A, 32'h0000_0011);
      check("bp_load_B", out_B, 32'h0000_0022);
      in_ready = 1'b0;
      instr(5'd2, 5'd1, 5'd12, 1'b1, 1'b0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_ready", {31'b0, out_ready}, 32'h0);
         step();
         check("bp_hold_A", out_A, 32'h0000_0011);
         check("bp_hold_rd", {27'b0, out_rd}, 32'd11);
         check("bp_hold_valid", {31'b0, out_valid}, 32'h1);
      end
      in_ready = 1'b1;
      #1;
      check("bp_release", {31'b0, out_ready}, 32'h1);
      step();
      check("bp_next_A", out_A, 32'h0000_0022);
      check("bp_next_B", out_B, 32'h0000_0011);
      check("bp_next_rd", {27'b0, out_rd}, 32'd12);
      check("bp_busy", dut.busy, 32'h0000_1C00);

      // WAW and RAW on rb
      instr(5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 32'h0);
      #1;
      check("waw_stall", {31'b0, out_ready}, 32'h0);
      instr(5'd0, 5'd11, 5'd0, 1'b0, 1'b0, 32'h0);
      #1;
      check("rawB_stall", {31'b0, out_ready}, 32'h0);
      step();

      // Reset mid-stream
      instr(5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0);
      step();
      in_valid = 1'b0;
      check("mid_busy5", dut.busy, 32'h0000_1C20);
      check("mid_A", out_A, 32'h0000_0004);
      #2;
      in_rst = 1'b1;
      #1;
      check("arst_valid", {31'b0, out_valid}, 32'h0);
      check("arst_A", out_A, 32'h0);
      check("arst_busy", dut.busy, 32'h0);
      #1;
      in_rst = 1'b0;
      step();

      // Capture set beats write-back clear on the same bit
      instr(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'h0);
      wb(1'b1, 5'd3, 32'h0000_0099);
      step();
      check("prec_busy", dut.busy, 32'h0000_0008);
      check("prec_wr_en", {31'b0, out_wr_en}, 32'h1);
      in_valid = 1'b0;
      wb(1'b0, 5'd0, 32'h0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
